// File: rtl/approx_mul_controller.sv
// Batch sequencer for the approximate-multiplier datapath: file load, eight
// fetch/search/multiply/rescale/write passes over the operand pairs, file dump.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// INIT  | pulse readFile, clear lastPair
// LDA   | capture A from the input RAM, advance RAM address
// LDB   | capture B, advance RAM address, latch last-pair carry
// SRCHA | walk counter A down to the leading one (or bit 7)
// SRCHB | walk counter B down to the leading one (or bit 7)
// MUL   | result <= extended product
// SHFT  | result <= rescaled (shifted) product
// WR    | write result to output RAM, rewind A/B counters
// DUMP  | pulse writeFile
// DONE  | pulse done
module approx_mul_controller (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic coCntRam,
  input  logic coA,
  input  logic coB,
  input  logic signA,
  input  logic signB,
  output logic enCntRam,
  output logic enReadInRam,
  output logic enWriteInRam,
  output logic enReadOutRam,
  output logic enWriteOutRam,
  output logic loadA,
  output logic loadB,
  output logic enCntA,
  output logic enCntB,
  output logic loadOut,
  output logic select,
  output logic readFile,
  output logic writeFile,
  output logic busy,
  output logic done
);

  typedef enum logic [3:0] {
    IDLE, INIT, LDA, LDB, SRCHA, SRCHB, MUL, SHFT, WR, DUMP, DONE
  } stateT;

  stateT state, nextState;
  logic  lastPair;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // coCntRam is only meaningful in LDB, before the RAM counter wraps.
  always_ff @(posedge clk) begin
    if (rst)                lastPair <= 1'b0;
    else if (state == INIT) lastPair <= 1'b0;
    else if (state == LDB)  lastPair <= coCntRam;
  end

  always_comb begin
    nextState     = state;
    enCntRam      = 1'b0;
    enReadInRam   = 1'b0;
    enWriteInRam  = 1'b0;
    enReadOutRam  = 1'b0;
    enWriteOutRam = 1'b0;
    loadA         = 1'b0;
    loadB         = 1'b0;
    enCntA        = 1'b0;
    enCntB        = 1'b0;
    loadOut       = 1'b0;
    select        = 1'b0;
    readFile      = 1'b0;
    writeFile     = 1'b0;
    done          = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: if (start) nextState = INIT;
      INIT: begin
        readFile  = 1'b1;
        nextState = LDA;
      end
      LDA: begin
        enReadInRam = 1'b1;
        loadA       = 1'b1;
        enCntRam    = 1'b1;
        nextState   = LDB;
      end
      LDB: begin
        enReadInRam = 1'b1;
        loadB       = 1'b1;
        enCntRam    = 1'b1;
        nextState   = SRCHA;
      end
      // Leaving a search state never counts, even when sign and carry coincide.
      SRCHA: begin
        if (!signA && !coA) enCntA    = 1'b1;
        else                nextState = SRCHB;
      end
      SRCHB: begin
        if (!signB && !coB) enCntB    = 1'b1;
        else                nextState = MUL;
      end
      MUL: begin
        select    = 1'b1;
        loadOut   = 1'b1;
        nextState = SHFT;
      end
      SHFT: begin
        loadOut   = 1'b1;
        nextState = WR;
      end
      WR: begin
        enWriteOutRam = 1'b1;
        nextState     = lastPair ? DUMP : LDA;
      end
      DUMP: begin
        writeFile = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_approx_mul_controller.sv
// Scoreboard bench: a behavioural datapath drives the status flags, and per-pair and
// per-batch timing is predicted from operand leading-one positions.
module tb_approx_mul_controller;

  logic clk = 1'b0;
  logic rst, start;
  logic coCntRam, coA, coB, signA, signB;
  logic enCntRam, enReadInRam, enWriteInRam, enReadOutRam, enWriteOutRam;
  logic loadA, loadB, enCntA, enCntB, loadOut, select;
  logic readFile, writeFile, busy, done;

  approx_mul_controller dut (
    .clk(clk), .rst(rst), .start(start),
    .coCntRam(coCntRam), .coA(coA), .coB(coB), .signA(signA), .signB(signB),
    .enCntRam(enCntRam), .enReadInRam(enReadInRam), .enWriteInRam(enWriteInRam),
    .enReadOutRam(enReadOutRam), .enWriteOutRam(enWriteOutRam),
    .loadA(loadA), .loadB(loadB), .enCntA(enCntA), .enCntB(enCntB),
    .loadOut(loadOut), .select(select),
    .readFile(readFile), .writeFile(writeFile), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire [14:0] outVec = {enCntRam, enReadInRam, enWriteInRam, enReadOutRam, enWriteOutRam,
                        loadA, loadB, enCntA, enCntB, loadOut, select,
                        readFile, writeFile, busy, done};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Datapath behaviour: RAM address counter, operand registers, bit-position counters.
  logic [15:0] ram [16];
  logic [15:0] fileQ[$];
  logic [3:0]  ramCnt, cntA, cntB;
  logic [15:0] regA, regB;

  always @(posedge clk) begin
    if (rst) begin
      ramCnt <= 4'd0;
      cntA   <= 4'd15;
      cntB   <= 4'd15;
      regA   <= 16'd0;
      regB   <= 16'd0;
    end else if (readFile) begin
      for (int i = 0; i < 16; i++)
        if (fileQ.size() > 0) ram[i] <= fileQ.pop_front();
      ramCnt <= 4'd0;
      cntA   <= 4'd15;
      cntB   <= 4'd15;
    end else begin
      if (enCntRam) ramCnt <= ramCnt + 4'd1;
      if (loadA)    regA   <= ram[ramCnt];
      if (loadB)    regB   <= ram[ramCnt];
      if (enWriteOutRam) begin
        cntA <= 4'd15;
        cntB <= 4'd15;
      end else begin
        if (enCntA) cntA <= cntA - 4'd1;
        if (enCntB) cntB <= cntB - 4'd1;
      end
    end
  end

  assign coCntRam = (ramCnt == 4'd15);
  assign coA      = (cntA == 4'd7);
  assign coB      = (cntB == 4'd7);
  assign signA    = regA[cntA];
  assign signB    = regB[cntB];

  // Reference model: search length from the leading-one position.
  function automatic int kOf(input logic [15:0] v);
    for (int p = 15; p >= 8; p--)
      if (v[p]) return 15 - p;
    return 8;
  endfunction

  typedef struct {
    int idx;
    int cyc;
    int ka;
    int kb;
  } pairExpT;

  pairExpT     expPairQ[$];
  int          expBatchQ[$];
  logic [15:0] img [16];

  task automatic pushBatch();
    int      sum;
    pairExpT e;
    sum = 0;
    for (int i = 0; i < 16; i++) fileQ.push_back(img[i]);
    for (int i = 0; i < 8; i++) begin
      e.idx = i;
      e.ka  = kOf(img[2*i]);
      e.kb  = kOf(img[2*i+1]);
      e.cyc = 7 + e.ka + e.kb;
      sum  += e.cyc;
      expPairQ.push_back(e);
    end
    expBatchQ.push_back(1 + sum + 2);
  endtask

  task automatic randImg();
    int          p;
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      p = $urandom_range(0, 16);
      if (p == 16) img[i] = 16'd0;
      else begin
        w      = (32'd1 << p) | ($urandom & ((32'd1 << p) - 32'd1));
        img[i] = w[15:0];
      end
    end
  endtask

  // Monitor: measures what the DUT does and pops the model's predictions.
  int      batchCyc = 0, pairCyc = 0, na = 0, nb = 0;
  int      rfCount = 0, wrCount = 0, wfCount = 0;
  bit      inBatch = 0, prevWr = 0, prevWf = 0;
  pairExpT got;
  logic [3:0] wrAddr;

  always @(negedge clk) begin
    if (rst) begin
      inBatch = 0; rfCount = 0; wrCount = 0; wfCount = 0;
      prevWr  = 0; prevWf  = 0; pairCyc = 0;
    end else begin
      chk("unused_enables", {enWriteInRam, enReadOutRam}, 0);
      if (readFile) begin
        rfCount++;
        if (!inBatch) begin
          batchCyc = 0; wrCount = 0; wfCount = 0;
        end
        inBatch = 1;
      end
      if (inBatch) batchCyc++;
      chk("busy", busy, inBatch);
      if (loadA) begin
        pairCyc = 1; na = 0; nb = 0;
      end else pairCyc++;
      if (enCntA) na++;
      if (enCntB) nb++;
      if (enWriteOutRam) begin
        wrCount++;
        if (expPairQ.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          got    = expPairQ.pop_front();
          wrAddr = ramCnt - 4'd1;
          chk("pair_cycles", pairCyc, got.cyc);
          chk("enCntA_cycles", na, got.ka);
          chk("enCntB_cycles", nb, got.kb);
          chk("write_addr", int'(wrAddr[3:1]), got.idx);
        end
      end
      if (writeFile) begin
        wfCount++;
        chk("writeFile_after_8_wr", wrCount, 8);
        chk("writeFile_follows_wr", prevWr, 1);
      end
      if (done) begin
        chk("done_follows_writeFile", prevWf, 1);
        if (expBatchQ.size() == 0) chk("unexpected_done", 1, 0);
        else chk("batch_cycles", batchCyc, expBatchQ.pop_front());
        chk("readFile_per_batch", rfCount, 1);
        chk("writeFile_per_batch", wfCount, 1);
        chk("writes_per_batch", wrCount, 8);
        inBatch = 0;
        rfCount = 0;
      end
      prevWr = enWriteOutRam;
      prevWf = writeFile;
    end
  end

  task automatic waitDone(input int limit, input bit toggle);
    bit seen;
    seen = 0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (toggle) start = 1'($urandom_range(0, 1));
    end
    if (toggle) start = 1'b0;
    chk("done_seen", seen, 1);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    bit found;
    int nLdb;

    // Reset held with start high.
    rst   = 1'b1;
    start = 1'b1;
    randImg();
    pushBatch();
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs", int'(outVec), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("start_latency_readFile", readFile, 1);
    start = 1'b0;
    waitDone(400, 0);

    // Best case: every operand has bit 15 set.
    for (int i = 0; i < 16; i++) img[i] = 16'h8000 | 16'($urandom);
    pushBatch();
    pulseStart();
    waitDone(400, 0);

    // Mixed operands on pair 0.
    randImg();
    img[0] = 16'h0100;
    img[1] = 16'h0000;
    pushBatch();
    pulseStart();
    waitDone(400, 0);

    // Random batches with start toggling while busy.
    for (int b = 0; b < 3; b++) begin
      randImg();
      pushBatch();
      pulseStart();
      waitDone(400, 1);
    end

    // start held across DONE: two back-to-back batches.
    randImg();
    pushBatch();
    randImg();
    pushBatch();
    @(negedge clk);
    start = 1'b1;
    waitDone(400, 0);
    waitDone(400, 0);
    start = 1'b0;

    // Reset during SRCHB of pair 3.
    randImg();
    img[6] = 16'h8000;
    img[7] = 16'h0000;
    pushBatch();
    pulseStart();
    found = 0;
    nLdb  = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (loadB) nLdb++;
      if (nLdb == 4) found = 1;
    end
    chk("reached_pair3_ldb", found, 1);
    @(negedge clk);
    @(negedge clk);
    chk("in_srchb_pair3", enCntB, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_reset_outputs", int'(outVec), 0);
    @(negedge clk);
    chk("midop_reset_outputs_hold", int'(outVec), 0);
    rst = 1'b0;
    expPairQ.delete();
    expBatchQ.delete();
    repeat (2) begin
      @(negedge clk);
      chk("idle_after_reset", int'(outVec), 0);
    end
    randImg();
    pushBatch();
    pulseStart();
    waitDone(400, 0);

    repeat (3) @(negedge clk);
    chk("pending_pairs", expPairQ.size(), 0);
    chk("pending_batches", expBatchQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
